// File: rtl/calc_add_ctrl.sv
// calc_add_ctrl: key-driven sequencer feeding the shared 4-bit calculator adder and latching its sum
module calc_add_ctrl #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_num_valid,
  input  logic [3:0] i_key_num,
  input  logic       i_key_plus,
  input  logic       i_key_eq,
  input  logic       i_key_clr,
  output logic [3:0] o_add_a,
  output logic [3:0] o_add_b,
  input  logic [5:0] i_add_sum,
  output logic [5:0] o_result,
  output logic       o_result_valid,
  output logic       o_busy,
  output logic       o_err,
  output logic [5:0] o_disp_data,
  output logic [2:0] o_state
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A    = 3'd1,
    S_BW   = 3'd2,
    S_B    = 3'd3,
    S_EXEC = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;
  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_add_a, w_add_a_nxt;
  logic [3:0] r_add_b, w_add_b_nxt;
  logic [5:0] r_result, w_result_nxt;
  logic       r_result_valid, w_result_valid_nxt;
  logic       w_eq, w_plus, w_num;
  // Only the highest-priority key acts: CLR > EQ > PLUS > NUM
  assign w_eq   = i_key_eq & ~i_key_clr;
  assign w_plus = i_key_plus & ~i_key_eq & ~i_key_clr;
  assign w_num  = i_key_num_valid & ~i_key_plus & ~i_key_eq & ~i_key_clr;
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_add_a        <= '0;
      r_add_b        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_add_a        <= w_add_a_nxt;
      r_add_b        <= w_add_b_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
    end
  end
  // Next-state and register updates driven by the decoded key
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_add_a_nxt        = r_add_a;
    w_add_b_nxt        = r_add_b;
    w_result_nxt       = r_result;
    w_result_valid_nxt = 1'b0;
    if (i_key_clr) begin
      w_state_nxt  = S_IDLE;
      w_add_a_nxt  = '0;
      w_add_b_nxt  = '0;
      w_result_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_num) begin
          w_add_a_nxt = i_key_num;
          w_state_nxt = S_A;
        end
        S_A: begin
          if (w_num) w_add_a_nxt = i_key_num;
          if (w_plus) w_state_nxt = S_BW;
        end
        S_BW: if (w_num) begin
          w_add_b_nxt = i_key_num;
          w_state_nxt = S_B;
        end
        S_B: begin
          if (w_num) w_add_b_nxt = i_key_num;
          if (w_eq) begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
          else begin
            w_result_nxt       = i_add_sum;
            w_result_valid_nxt = 1'b1;
            w_state_nxt        = S_DONE;
          end
        end
        S_DONE: begin
          if (w_num) begin
            w_add_a_nxt = i_key_num;
            w_add_b_nxt = '0;
            w_state_nxt = S_A;
          end else if (w_plus && r_result <= 6'd15) begin
            w_add_a_nxt = r_result[3:0];
            w_add_b_nxt = '0;
            w_state_nxt = S_BW;
          end else if (w_plus) w_state_nxt = S_ERR;
        end
        S_ERR: w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end
  assign o_add_a        = r_add_a;
  assign o_add_b        = r_add_b;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = r_state == S_EXEC;
  assign o_err          = r_state == S_ERR;
  assign o_state        = r_state;
  // Display selection decoded from the current state
  always_comb begin
    o_disp_data = (r_state == S_A || r_state == S_BW) ? {2'b00, r_add_a} :
                  (r_state == S_B || r_state == S_EXEC) ? {2'b00, r_add_b} :
                  (r_state == S_DONE) ? r_result :
                  (r_state == S_ERR) ? 6'h3F : 6'h00;
  end
endmodule

// File: tb/tb_calc_add_ctrl.sv
// tb_calc_add_ctrl: two instances (1 and 4 settle cycles) against a key-level calculator model
module tb_calc_add_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       nv = 1'b0, pl = 1'b0, eq = 1'b0, clr = 1'b0;
  logic [3:0] num = '0;
  logic [3:0] add_a [2];
  logic [3:0] add_b [2];
  logic [5:0] add_sum [2];
  logic [5:0] result [2];
  logic [5:0] disp [2];
  logic [2:0] state [2];
  logic       rv [2];
  logic       busy [2];
  logic       err [2];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {int ph; int a; int b; int res; int rv; int rem;} mdl_t;
  mdl_t m [2];
  int   ex [2] = '{1, 4};
  always #5 clk = ~clk;
  assign add_sum[0] = {2'b00, add_a[0]} + {2'b00, add_b[0]};
  assign add_sum[1] = {2'b00, add_a[1]} + {2'b00, add_b[1]};
  calc_add_ctrl #(.EXEC_CYCLES(1)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_num_valid(nv), .i_key_num(num),
    .i_key_plus(pl), .i_key_eq(eq), .i_key_clr(clr),
    .o_add_a(add_a[0]), .o_add_b(add_b[0]), .i_add_sum(add_sum[0]),
    .o_result(result[0]), .o_result_valid(rv[0]), .o_busy(busy[0]), .o_err(err[0]),
    .o_disp_data(disp[0]), .o_state(state[0]));
  calc_add_ctrl #(.EXEC_CYCLES(4)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_num_valid(nv), .i_key_num(num),
    .i_key_plus(pl), .i_key_eq(eq), .i_key_clr(clr),
    .o_add_a(add_a[1]), .o_add_b(add_b[1]), .i_add_sum(add_sum[1]),
    .o_result(result[1]), .o_result_valid(rv[1]), .o_busy(busy[1]), .o_err(err[1]),
    .o_disp_data(disp[1]), .o_state(state[1]));
  function automatic mdl_t mstep(mdl_t s, int lat, logic k_nv, int k_num, logic k_pl, logic k_eq, logic k_clr);
    int key;
    key = k_clr ? 4 : k_eq ? 3 : k_pl ? 2 : k_nv ? 1 : 0;
    s.rv = 0;
    if (key == 4) return '{0, 0, 0, 0, 0, 0};
    case (s.ph)
      0: if (key == 1) begin s.a = k_num; s.ph = 1; end
      1: if (key == 1) s.a = k_num; else if (key == 2) s.ph = 2;
      2: if (key == 1) begin s.b = k_num; s.ph = 3; end
      3: if (key == 1) s.b = k_num; else if (key == 3) begin s.ph = 4; s.rem = lat; end
      4: begin
        s.rem--;
        if (s.rem == 0) begin s.res = s.a + s.b; s.rv = 1; s.ph = 5; end
      end
      5: if (key == 1) begin s.a = k_num; s.b = 0; s.ph = 1; end
         else if (key == 2 && s.res <= 15) begin s.a = s.res; s.b = 0; s.ph = 2; end
         else if (key == 2) s.ph = 6;
      default: ;
    endcase
    return s;
  endfunction
  function automatic int mdisp(mdl_t s);
    return (s.ph == 1 || s.ph == 2) ? s.a : (s.ph == 3 || s.ph == 4) ? s.b :
           (s.ph == 5) ? s.res : (s.ph == 6) ? 63 : 0;
  endfunction
  task automatic chk(string tag, int idx, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("state", i, 8'(state[i]), 8'(m[i].ph));
      chk("add_a", i, 8'(add_a[i]), 8'(m[i].a));
      chk("add_b", i, 8'(add_b[i]), 8'(m[i].b));
      chk("result", i, 8'(result[i]), 8'(m[i].res));
      chk("result_valid", i, 8'(rv[i]), 8'(m[i].rv));
      chk("busy", i, 8'(busy[i]), 8'(m[i].ph == 4));
      chk("err", i, 8'(err[i]), 8'(m[i].ph == 6));
      chk("disp", i, 8'(disp[i]), 8'(mdisp(m[i])));
    end
  endtask
  task automatic cycle(logic k_nv, int k_num, logic k_pl, logic k_eq, logic k_clr);
    nv = k_nv; num = 4'(k_num); pl = k_pl; eq = k_eq; clr = k_clr;
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = mstep(m[i], ex[i], k_nv, k_num, k_pl, k_eq, k_clr);
    #1;
    nv = 0; pl = 0; eq = 0; clr = 0;
    check_all();
  endtask
  task automatic key_num(int v); cycle(1, v, 0, 0, 0); endtask
  task automatic key_plus(); cycle(0, 0, 1, 0, 0); endtask
  task automatic key_eq(); cycle(0, 0, 0, 1, 0); endtask
  task automatic key_clr(); cycle(0, 0, 0, 0, 1); endtask
  task automatic idle(int n); for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0); endtask
  initial begin
    for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 0, 0, 0};
    #3;
    check_all();
    #9 rst_n = 1'b1;
    key_num(3); key_plus(); key_num(4); key_eq(); idle(4);
    chk("sum3p4", 0, 8'(result[0]), 8'd7);
    key_clr();
    key_num(15); key_plus(); key_num(15); key_eq(); idle(4);
    chk("sum15p15", 1, 8'(result[1]), 8'h1E);
    key_plus();
    chk("err_disp", 0, 8'(disp[0]), 8'h3F);
    key_num(6); key_eq(); idle(1); key_clr();
    key_num(2); key_plus(); key_num(5); key_eq(); idle(4);
    key_plus(); key_num(8); key_eq(); idle(4);
    chk("chain15", 1, 8'(result[1]), 8'd15);
    key_plus(); key_num(1); key_eq();
    key_num(9); key_plus(); key_eq(); idle(4);
    chk("chain16", 1, 8'(result[1]), 8'd16);
    key_num(5); key_plus(); key_num(7);
    key_num(11); key_num(1);
    cycle(1, 9, 0, 0, 1);
    key_num(6); cycle(1, 2, 1, 1, 0); cycle(1, 3, 1, 0, 0); key_num(12);
    cycle(0, 0, 1, 1, 0); idle(5);
    key_clr(); key_num(7); key_plus(); key_num(8); key_eq(); idle(1);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = '{0, 0, 0, 0, 0, 0};
    #1 check_all();
    #2 rst_n = 1'b1;
    idle(3);
    for (int k = 0; k < 600; k++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
